// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Sequences single load/store requests from the core datapath into
//            a 16-word registered data memory. Computes the effective address,
//            strobes MemRead/MemWrite for one cycle, absorbs the memory's
//            one-cycle read latency and returns load data with a valid pulse.
//            Out-of-range addresses raise a fault pulse without touching the
//            memory. Saturating load/store completion counters for debug.
// Ports    : clk, nClear (async active-low reset)
//            req_*      : request from core (valid/ready handshake)
//            mem_*, MemRead, MemWrite : data memory interface
//            ld_valid/ld_data/ld_rd    : load response
//            st_done, fault            : completion / error pulses
//            ld_count, st_count        : saturating debug counters
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int DEPTH_BITS = 4
) (
    input  logic        clk,
    input  logic        nClear,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_base,
    input  logic [15:0] req_offset,
    input  logic [15:0] req_wdata,
    input  logic [3:0]  req_rd,
    output logic        req_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [15:0] mem_rdata,
    output logic        ld_valid,
    output logic [15:0] ld_data,
    output logic [3:0]  ld_rd,
    output logic        st_done,
    output logic        fault,
    output logic [15:0] ld_count,
    output logic [15:0] st_count
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_req_ready;
    logic        r_write;
    logic [3:0]  r_rd;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_ld_data;
    logic [3:0]  r_ld_rd;
    logic [15:0] r_ld_count;
    logic [15:0] r_st_count;

    logic [15:0] w_ea;
    logic        w_in_range;
    logic        w_accept;

    // Effective address wraps modulo 2^16; any bit above the memory index
    // marks the access as out of range.
    assign w_ea       = req_base + req_offset;
    assign w_in_range = (w_ea[15:DEPTH_BITS] == '0);

    // r_req_ready is low for the first cycle after reset release, so the
    // state check alone is not enough to accept.
    assign w_accept   = (r_state == S_IDLE) && r_req_ready && req_valid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_in_range ? S_ISSUE : S_FAULT;
                end
            end
            S_ISSUE: w_next_state = r_write ? S_RESP : S_WAIT;
            S_WAIT:  w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            S_FAULT: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            // Registered ready: high in every cycle spent in IDLE, and first
            // rises on the edge after reset release.
            r_req_ready <= (w_next_state == S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Request capture and memory-side address/data registers.
    // mem_addr/mem_wdata only change when an in-range access is accepted,
    // so they hold their last driven values through faults and idle time.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            r_write     <= 1'b0;
            r_rd        <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_rd    <= req_rd;
            if (w_in_range) begin
                r_mem_addr <= w_ea;
                if (req_write) begin
                    r_mem_wdata <= req_wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load response capture: the memory output is valid during WAIT, so the
    // result lands in ld_data exactly as RESP begins and then holds until the
    // next load reaches the same point.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            r_ld_data <= '0;
            r_ld_rd   <= '0;
        end else if (r_state == S_WAIT) begin
            r_ld_data <= mem_rdata;
            r_ld_rd   <= r_rd;
        end
    end

    // ------------------------------------------------------------------
    // Saturating completion counters, stepped on the edge that ends RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            r_ld_count <= '0;
            r_st_count <= '0;
        end else if (r_state == S_RESP) begin
            if (!r_write && (r_ld_count != c_CNT_MAX)) begin
                r_ld_count <= r_ld_count + 16'd1;
            end
            if (r_write && (r_st_count != c_CNT_MAX)) begin
                r_st_count <= r_st_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes and pulses decode straight from the state register,
    // so an asynchronous reset removes them immediately.
    // ------------------------------------------------------------------
    assign req_ready = r_req_ready;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign MemRead   = (r_state == S_ISSUE) && !r_write;
    assign MemWrite  = (r_state == S_ISSUE) &&  r_write;
    assign ld_valid  = (r_state == S_RESP)  && !r_write;
    assign st_done   = (r_state == S_RESP)  &&  r_write;
    assign fault     = (r_state == S_FAULT);
    assign ld_data   = r_ld_data;
    assign ld_rd     = r_ld_rd;
    assign ld_count  = r_ld_count;
    assign st_count  = r_st_count;

endmodule
`default_nettype wire
